// File: rtl/wiggle_pkg.sv
// Shared mode and direction encodings for the wiggle_pattern GPIO pattern generator.
package wiggle_pkg;

    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_WALK    = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef enum logic {
        DUTY_UP   = 1'b0,
        DUTY_DOWN = 1'b1
    } duty_dir_t;

    localparam int unsigned PWM_W    = 8;
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

endpackage

// File: rtl/wiggle_prescaler.sv
// Free-running prescaler: counts 0..DIV-1 and emits a registered one-cycle tick on each wrap.
module wiggle_prescaler
    import wiggle_pkg::*;
#(
    parameter int unsigned     CNT_W = 27,
    parameter longint unsigned DIV   = 64'd1 << CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pause,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 64'd1);

    if (CNT_W < 8) begin : g_bad_cnt_w
        $error("wiggle_prescaler: CNT_W must be >= 8");
    end
    if (DIV < 64'd2 || DIV > (64'd1 << CNT_W)) begin : g_bad_div
        $error("wiggle_prescaler: DIV must satisfy 2 <= DIV <= 2**CNT_W");
    end

    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = ~pause & (r_count == LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (!pause) begin
                r_count <= w_wrap ? '0 : r_count + 1'b1;
            end
        end
    end

    assign count = r_count;
    assign tick  = r_tick;

endmodule

// File: rtl/wiggle_pattern.sv
// GPIO/LED pattern generator: binary, walking one, bounce and PWM breathe engines
// advanced by the prescaler tick, with mode-change reload.
module wiggle_pattern
    import wiggle_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter int unsigned     CNT_W = 27,
    parameter longint unsigned DIV   = 64'd1 << CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic [WIDTH-1:0] gpio,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 64'd1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    if (WIDTH < 1) begin : g_bad_width
        $error("wiggle_pattern: WIDTH must be >= 1");
    end
    if (CNT_W < 8) begin : g_bad_cnt_w
        $error("wiggle_pattern: CNT_W must be >= 8");
    end
    if (DIV < 64'd2 || DIV > (64'd1 << CNT_W)) begin : g_bad_div
        $error("wiggle_pattern: DIV must satisfy 2 <= DIV <= 2**CNT_W");
    end

    logic [CNT_W-1:0] w_count;
    logic             w_adv;
    mode_t            w_mode;

    wiggle_prescaler #(
        .CNT_W (CNT_W),
        .DIV   (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rstn  (rstn),
        .pause (pause),
        .count (w_count),
        .tick  (tick)
    );

    assign count = w_count;
    // Same condition the prescaler uses to wrap, so the pattern step lands on the tick edge.
    assign w_adv  = ~pause & (w_count == LAST);
    assign w_mode = mode_t'(mode);

    mode_t            r_mode_q;
    logic [WIDTH-1:0] r_pat;
    dir_t             r_dir;
    logic [PWM_W-1:0] r_duty;
    duty_dir_t        r_duty_dir;
    logic             r_pwm;
    logic [WIDTH-1:0] r_gpio;

    logic [WIDTH-1:0] w_pat_nxt;
    dir_t             w_dir_nxt;
    logic [PWM_W-1:0] w_duty_nxt;
    duty_dir_t        w_duty_dir_nxt;
    logic             w_pwm_nxt;
    logic [WIDTH-1:0] w_gpio_nxt;

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [PWM_W-1:0] w_duty_inc;
    logic [PWM_W-1:0] w_duty_dec;

    assign w_shl      = r_pat << 1;
    assign w_shr      = r_pat >> 1;
    assign w_rol      = (r_pat << 1) | (r_pat >> (WIDTH - 1));
    assign w_duty_inc = r_duty + 1'b1;
    assign w_duty_dec = r_duty - 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mode_q   <= MODE_BIN;
            r_pat      <= '0;
            r_dir      <= DIR_LEFT;
            r_duty     <= '0;
            r_duty_dir <= DUTY_UP;
            r_pwm      <= 1'b0;
            r_gpio     <= '0;
        end else begin
            r_mode_q   <= w_mode;
            r_pat      <= w_pat_nxt;
            r_dir      <= w_dir_nxt;
            r_duty     <= w_duty_nxt;
            r_duty_dir <= w_duty_dir_nxt;
            r_pwm      <= w_pwm_nxt;
            r_gpio     <= w_gpio_nxt;
        end
    end

    always_comb begin
        w_pat_nxt      = r_pat;
        w_dir_nxt      = r_dir;
        w_duty_nxt     = r_duty;
        w_duty_dir_nxt = r_duty_dir;

        if (w_mode != r_mode_q) begin
            // Reload only the engine being entered; a coincident tick is dropped.
            unique case (w_mode)
                MODE_BIN: w_pat_nxt = '0;
                MODE_WALK, MODE_BOUNCE: begin
                    w_pat_nxt = ONE;
                    w_dir_nxt = DIR_LEFT;
                end
                MODE_BREATHE: begin
                    w_duty_nxt     = '0;
                    w_duty_dir_nxt = DUTY_UP;
                end
                default: ;
            endcase
        end else if (w_adv) begin
            unique case (r_mode_q)
                MODE_BIN:  w_pat_nxt = r_pat + 1'b1;
                MODE_WALK: w_pat_nxt = w_rol;
                MODE_BOUNCE: begin
                    if (WIDTH > 1) begin
                        if (r_dir == DIR_LEFT) begin
                            w_pat_nxt = w_shl;
                            if (w_shl[WIDTH-1]) w_dir_nxt = DIR_RIGHT;
                        end else begin
                            w_pat_nxt = w_shr;
                            if (w_shr[0]) w_dir_nxt = DIR_LEFT;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (r_duty_dir == DUTY_UP) begin
                        w_duty_nxt = w_duty_inc;
                        if (w_duty_inc == DUTY_MAX) w_duty_dir_nxt = DUTY_DOWN;
                    end else begin
                        w_duty_nxt = w_duty_dec;
                        if (w_duty_dec == '0) w_duty_dir_nxt = DUTY_UP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // Holding the compare while paused keeps the breathe output frozen with the count.
        w_pwm_nxt  = pause ? r_pwm : (w_count[PWM_W-1:0] < r_duty);
        w_gpio_nxt = (w_mode == MODE_BREATHE) ? {WIDTH{w_pwm_nxt}} : w_pat_nxt;
    end

    assign gpio = r_gpio;

endmodule

// File: tb/tb_wiggle_pattern.sv
// Self-checking bench for wiggle_pattern against a tick-count based reference model.
module tb_wiggle_pattern;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a = 1'b0, pause_a = 1'b0;
    logic [1:0] mode_a = 2'd0;
    logic [3:0] gpio_a;
    logic [7:0] count_a;
    logic       tick_a;

    logic       rstn_b = 1'b0, pause_b = 1'b0;
    logic [1:0] mode_b = 2'd0;
    logic [3:0] gpio_b;
    logic [7:0] count_b;
    logic       tick_b;

    wiggle_pattern #(.WIDTH(4), .CNT_W(8), .DIV(4)) dut_a (
        .clk(clk), .rstn(rstn_a), .mode(mode_a), .pause(pause_a),
        .gpio(gpio_a), .count(count_a), .tick(tick_a)
    );

    wiggle_pattern #(.WIDTH(4), .CNT_W(8), .DIV(256)) dut_b (
        .clk(clk), .rstn(rstn_b), .mode(mode_b), .pause(pause_b),
        .gpio(gpio_b), .count(count_b), .tick(tick_b)
    );

    int total = 0;
    int bad   = 0;

    // Model state: counts of ticks since each engine was (re)entered.
    int unsigned m_cnt [2];
    int unsigned m_mq  [2];
    int unsigned m_np  [2];
    int unsigned m_nb  [2];
    bit          m_tick[2];
    bit          m_pwm [2];

    function automatic int unsigned div_of(int i);
        return (i == 0) ? 4 : 256;
    endfunction

    function automatic int unsigned duty_of(int unsigned nb);
        int unsigned k;
        k = nb % 510;
        return (k <= 255) ? k : 510 - k;
    endfunction

    function automatic logic [3:0] pat_of(int unsigned mq, int unsigned np);
        int unsigned k, pos;
        case (mq)
            0: return 4'(np % 16);
            1: return 4'(1 << (np % 4));
            2: begin
                k   = np % 6;
                pos = (k <= 3) ? k : 6 - k;
                return 4'(1 << pos);
            end
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] exp_gpio(int i);
        if (m_mq[i] == 3) return m_pwm[i] ? 4'hF : 4'h0;
        return pat_of(m_mq[i], m_np[i]);
    endfunction

    task automatic model_edge(int i, logic rs, logic pz, logic [1:0] md);
        bit wrap;
        if (!rs) begin
            m_cnt[i] = 0; m_tick[i] = 0; m_mq[i] = 0;
            m_np[i]  = 0; m_nb[i]   = 0; m_pwm[i] = 0;
        end else begin
            wrap = !pz && (m_cnt[i] == div_of(i) - 1);
            if (!pz) begin
                m_pwm[i] = ((m_cnt[i] % 256) < duty_of(m_nb[i]));
                m_cnt[i] = (m_cnt[i] + 1) % div_of(i);
            end
            m_tick[i] = wrap;
            if (int'(md) != m_mq[i]) begin
                if (md == 2'd3) m_nb[i] = 0; else m_np[i] = 0;
                m_mq[i] = md;
            end else if (wrap) begin
                if (m_mq[i] == 3) m_nb[i]++; else m_np[i]++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0, rstn_a, pause_a, mode_a);
        model_edge(1, rstn_b, pause_b, mode_b);
        #1;
    endtask

    task automatic test_reset();
        rstn_a = 1'b0; mode_a = 2'd0; pause_a = 1'b0;
        repeat (3) begin
            cyc();
            total++; if (gpio_a !== 4'h0) begin bad++; $display("FAIL reset_gpio got=%h exp=0", gpio_a); end
            total++; if (count_a !== 8'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", count_a); end
            total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick_a); end
        end
        rstn_a = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            total++; if (count_a !== 8'(m_cnt[0])) begin bad++; $display("FAIL run_count cyc=%0d got=%0d exp=%0d", c, count_a, m_cnt[0]); end
            total++; if (tick_a !== m_tick[0]) begin bad++; $display("FAIL run_tick cyc=%0d got=%b exp=%b", c, tick_a, m_tick[0]); end
            total++; if (gpio_a !== exp_gpio(0)) begin bad++; $display("FAIL run_gpio cyc=%0d got=%h exp=%h", c, gpio_a, exp_gpio(0)); end
        end
    endtask

    task automatic test_binary();
        int nt;
        rstn_a = 1'b0; mode_a = 2'd0; cyc(); rstn_a = 1'b1;
        nt = 0;
        for (int c = 0; c < 100 && nt < 17; c++) begin
            cyc();
            total++; if (tick_a !== m_tick[0]) begin bad++; $display("FAIL bin_tick got=%b exp=%b", tick_a, m_tick[0]); end
            total++; if (gpio_a !== exp_gpio(0)) begin bad++; $display("FAIL bin_gpio got=%h exp=%h", gpio_a, exp_gpio(0)); end
            if (m_tick[0]) begin
                nt++;
                if (nt == 15) begin total++; if (gpio_a !== 4'hF) begin bad++; $display("FAIL bin_15 got=%h exp=f", gpio_a); end end
                if (nt == 16) begin total++; if (gpio_a !== 4'h0) begin bad++; $display("FAIL bin_wrap got=%h exp=0", gpio_a); end end
            end
        end
        total++; if (nt != 17) begin bad++; $display("FAIL bin_timeout got=%0d exp=17", nt); end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [8];
        int idx;
        seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        rstn_a = 1'b0; mode_a = 2'd2; cyc(); rstn_a = 1'b1;
        cyc();
        total++; if (gpio_a !== seq[0]) begin bad++; $display("FAIL bounce_load got=%h exp=%h", gpio_a, seq[0]); end
        idx = 1;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            cyc();
            total++; if (gpio_a !== exp_gpio(0)) begin bad++; $display("FAIL bounce_gpio got=%h exp=%h", gpio_a, exp_gpio(0)); end
            if (m_tick[0]) begin
                total++; if (gpio_a !== seq[idx]) begin bad++; $display("FAIL bounce_seq%0d got=%h exp=%h", idx, gpio_a, seq[idx]); end
                idx++;
            end
        end
        total++; if (idx != 8) begin bad++; $display("FAIL bounce_timeout got=%0d exp=8", idx); end
    endtask

    task automatic test_mode_switch();
        logic [3:0] seq [4];
        int  idx;
        bit  found;
        seq = '{4'h2, 4'h4, 4'h8, 4'h1};
        rstn_a = 1'b0; mode_a = 2'd0; cyc(); rstn_a = 1'b1;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            cyc();
            total++; if (gpio_a !== exp_gpio(0)) begin bad++; $display("FAIL msw_pre got=%h exp=%h", gpio_a, exp_gpio(0)); end
            if (m_tick[0] && pat_of(0, m_np[0]) == 4'h5) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL msw_timeout got=0 exp=1"); end
        mode_a = 2'd1;
        cyc();
        total++; if (gpio_a !== 4'h1) begin bad++; $display("FAIL msw_reload got=%h exp=1", gpio_a); end
        total++; if (count_a !== 8'd1) begin bad++; $display("FAIL msw_count got=%0d exp=1", count_a); end
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            cyc();
            total++; if (count_a !== 8'(m_cnt[0])) begin bad++; $display("FAIL msw_cnt got=%0d exp=%0d", count_a, m_cnt[0]); end
            if (m_tick[0]) begin
                total++; if (gpio_a !== seq[idx]) begin bad++; $display("FAIL msw_walk%0d got=%h exp=%h", idx, gpio_a, seq[idx]); end
                idx++;
            end
        end
        total++; if (idx != 4) begin bad++; $display("FAIL msw_walk_timeout got=%0d exp=4", idx); end
    endtask

    task automatic test_pause_reset();
        int unsigned snap_cnt;
        logic [3:0]  snap_gpio;
        bit          seen;
        rstn_a = 1'b0; mode_a = 2'd2; cyc(); rstn_a = 1'b1;
        repeat (5 + $urandom_range(0, 7)) cyc();
        pause_a = 1'b1;
        snap_cnt = m_cnt[0]; snap_gpio = exp_gpio(0);
        for (int c = 0; c < 10; c++) begin
            cyc();
            total++; if (count_a !== 8'(snap_cnt)) begin bad++; $display("FAIL pause_count got=%0d exp=%0d", count_a, snap_cnt); end
            total++; if (gpio_a !== snap_gpio) begin bad++; $display("FAIL pause_gpio got=%h exp=%h", gpio_a, snap_gpio); end
            total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL pause_tick got=%b exp=0", tick_a); end
        end
        mode_a = 2'd1; cyc();
        total++; if (gpio_a !== exp_gpio(0)) begin bad++; $display("FAIL pause_reload got=%h exp=%h", gpio_a, exp_gpio(0)); end
        total++; if (count_a !== 8'(snap_cnt)) begin bad++; $display("FAIL pause_reload_cnt got=%0d exp=%0d", count_a, snap_cnt); end
        mode_a = 2'd2; cyc();
        pause_a = 1'b0;
        for (int c = 0; c < 14; c++) begin
            pause_a = 1'($urandom_range(0, 1));
            cyc();
            total++; if (gpio_a !== exp_gpio(0)) begin bad++; $display("FAIL rndpause_gpio got=%h exp=%h", gpio_a, exp_gpio(0)); end
            total++; if (count_a !== 8'(m_cnt[0])) begin bad++; $display("FAIL rndpause_cnt got=%0d exp=%0d", count_a, m_cnt[0]); end
            total++; if (tick_a !== m_tick[0]) begin bad++; $display("FAIL rndpause_tick got=%b exp=%b", tick_a, m_tick[0]); end
        end
        pause_a = 1'b1; rstn_a = 1'b0; cyc();
        total++; if (gpio_a !== 4'h0) begin bad++; $display("FAIL rst_gpio got=%h exp=0", gpio_a); end
        total++; if (count_a !== 8'h0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count_a); end
        total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", tick_a); end
        pause_a = 1'b0; rstn_a = 1'b1; cyc();
        total++; if (gpio_a !== 4'h1) begin bad++; $display("FAIL rst_reload got=%h exp=1", gpio_a); end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cyc();
            if (m_tick[0]) begin
                seen = 1;
                total++; if (gpio_a !== 4'h2) begin bad++; $display("FAIL rst_left got=%h exp=2", gpio_a); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_tick_timeout got=0 exp=1"); end
    endtask

    task automatic test_breathe();
        int j, ones;
        rstn_b = 1'b0; mode_b = 2'd3; cyc(); rstn_b = 1'b1;
        j = 0; ones = 0;
        for (int c = 0; c < 70000 && j < 257; c++) begin
            cyc();
            total++; if (gpio_b !== exp_gpio(1)) begin bad++; $display("FAIL br_gpio cyc=%0d got=%h exp=%h", c, gpio_b, exp_gpio(1)); end
            if (j >= 1 && gpio_b === 4'hF) ones++;
            if (tick_b) begin
                if (j >= 1) begin
                    total++; if (ones != int'(duty_of(j))) begin bad++; $display("FAIL br_window%0d got=%0d exp=%0d", j, ones, duty_of(j)); end
                    if (j == 64)  begin total++; if (ones != 64)  begin bad++; $display("FAIL br_duty64 got=%0d exp=64", ones); end end
                    if (j == 255) begin total++; if (ones != 255) begin bad++; $display("FAIL br_top got=%0d exp=255", ones); end end
                    if (j == 256) begin total++; if (ones != 254) begin bad++; $display("FAIL br_turn got=%0d exp=254", ones); end end
                end
                j++; ones = 0;
            end
        end
        total++; if (j != 257) begin bad++; $display("FAIL br_timeout got=%0d exp=257", j); end
        rstn_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) model_edge(i, 1'b0, 1'b0, 2'd0);
        test_reset();
        test_binary();
        test_bounce();
        test_mode_switch();
        test_pause_reset();
        test_breathe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
